bpu_update_queue: RTL and testbench

Buffers resolved-branch records from the execute stage and drains them, one per cycle, into the update port of the naive BTB predictor. Sits between EX branch resolution and the BTB, so a stalled pipeline does not lose training information. Classifies each record as correct or mispredicted, computes the BTB update strobes, and counts records dropped on overflow.

---
 rtl/bpu_pkg.sv | 41 ++++
 rtl/bpu_sat_cnt.sv | 26 ++
 rtl/bpu_update_queue.sv | 112 +++++++++++
 tb/tb_bpu_update_queue.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | bpu_pkg                                                                |
// | Shared branch-update record layout and mispredict classification.      |
// | Used by bpu_update_queue now and by future PHT / RAS update paths.     |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package bpu_pkg;

  // Stored record: pc | real_address | real_direct | update_type | mis |
  // pred_address. The predicted target is carried for downstream trainers
  // that need the original guess; the BTB port itself does not read it.
  localparam int REC_W     = 99;
  localparam int PC_LSB    = 0;
  localparam int RADDR_LSB = 32;
  localparam int RDIR_BIT  = 64;
  localparam int UTYPE_BIT = 65;
  localparam int MIS_BIT   = 66;
  localparam int PADDR_LSB = 67;

  // A direction miss always counts; a target miss only matters when the
  // branch was actually taken (a not-taken branch has no useful target).
  function automatic logic mispredict(input logic        pred_direct,
                                      input logic [31:0] pred_address,
                                      input logic        real_direct,
                                      input logic [31:0] real_address);
    return (pred_direct != real_direct) |
           (real_direct & (pred_address != real_address));
  endfunction

  function automatic logic [REC_W-1:0] pack_rec(input logic [31:0] pc,
                                                input logic [31:0] real_address,
                                                input logic        real_direct,
                                                input logic        update_type,
                                                input logic        mis,
                                                input logic [31:0] pred_address);
    return {pred_address, mis, update_type, real_direct, real_address, pc};
  endfunction

endpackage
`default_nettype wire

// File: rtl/bpu_sat_cnt.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | bpu_sat_cnt                                                            |
// | Saturating up-counter with synchronous clear.                          |
// | Ports: clk, clr (sync clear, wins over inc), inc, cnt[CNT_W-1:0].     |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module bpu_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bpu_update_queue.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | bpu_update_queue                                                       |
// | FIFO of resolved-branch records between EX and the BTB update port.    |
// | Inputs : clk, resetn (sync, active low), stallreq, ex_* branch record. |
// | Outputs: head record (update_pc, real_direct, real_address,            |
// |          update_type), pred_flag / pred_true strobes, q_count,         |
// |          drop_cnt (overflow losses), mispred_cnt (mispredicts popped). |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module bpu_update_queue
  import bpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     stallreq,
  input  logic                     ex_valid,
  input  logic [31:0]              ex_pc,
  input  logic                     ex_pred_direct,
  input  logic [31:0]              ex_pred_address,
  input  logic                     ex_real_direct,
  input  logic [31:0]              ex_real_address,
  input  logic                     ex_update_type,
  output logic [31:0]              update_pc,
  output logic                     pred_flag,
  output logic                     pred_true,
  output logic                     real_direct,
  output logic [31:0]              real_address,
  output logic                     update_type,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [CNT_W-1:0]         mispred_cnt
);

  localparam int                AW      = $clog2(DEPTH);
  localparam logic [AW:0]       DEPTH_Q = (AW+1)'(DEPTH);

  logic [REC_W-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;

  logic             empty;
  logic             pop;
  logic             push;
  logic             head_mis;
  logic [REC_W-1:0] new_rec;

  assign empty = (count == '0);
  // The BTB updates on exactly the same condition, so this pop is the
  // BTB's consumption of the head record.
  assign pop   = ~empty & ~stallreq;
  // A full queue still accepts when its head leaves on the same edge.
  assign push  = ex_valid & ((count != DEPTH_Q) | pop);

  assign new_rec = pack_rec(ex_pc, ex_real_address, ex_real_direct, ex_update_type,
                            mispredict(ex_pred_direct, ex_pred_address,
                                       ex_real_direct, ex_real_address),
                            ex_pred_address);

  // Storage carries no reset; stale slots are never visible because the
  // outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= new_rec;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + 1'b1;  // power-of-two depth: natural wrap
      if (push) wr_ptr <= wr_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_mis     = mem[rd_ptr][MIS_BIT];
  assign update_pc    = empty ? 32'h0 : mem[rd_ptr][PC_LSB +: 32];
  assign real_address = empty ? 32'h0 : mem[rd_ptr][RADDR_LSB +: 32];
  assign real_direct  = ~empty & mem[rd_ptr][RDIR_BIT];
  assign update_type  = ~empty & mem[rd_ptr][UTYPE_BIT];
  assign pred_flag    = ~empty & head_mis;
  assign pred_true    = ~empty & ~head_mis;
  assign q_count      = count;

  bpu_sat_cnt #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk (clk),
    .clr (~resetn),
    .inc (ex_valid & ~push),
    .cnt (drop_cnt)
  );

  bpu_sat_cnt #(.CNT_W(CNT_W)) u_mispred_cnt (
    .clk (clk),
    .clr (~resetn),
    .inc (pop & head_mis),
    .cnt (mispred_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_bpu_update_queue.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_bpu_update_queue                                                    |
// | Directed and random stimulus against a queue-based reference model.   |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_bpu_update_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        stallreq = 1'b0;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_pc = '0;
  logic        ex_pred_direct = 1'b0;
  logic [31:0] ex_pred_address = '0;
  logic        ex_real_direct = 1'b0;
  logic [31:0] ex_real_address = '0;
  logic        ex_update_type = 1'b0;
  logic [31:0] update_pc;
  logic        pred_flag;
  logic        pred_true;
  logic        real_direct;
  logic [31:0] real_address;
  logic        update_type;
  logic [$clog2(DEPTH):0] q_count;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  always #5 clk = ~clk;

  bpu_update_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .stallreq        (stallreq),
    .ex_valid        (ex_valid),
    .ex_pc           (ex_pc),
    .ex_pred_direct  (ex_pred_direct),
    .ex_pred_address (ex_pred_address),
    .ex_real_direct  (ex_real_direct),
    .ex_real_address (ex_real_address),
    .ex_update_type  (ex_update_type),
    .update_pc       (update_pc),
    .pred_flag       (pred_flag),
    .pred_true       (pred_true),
    .real_direct     (real_direct),
    .real_address    (real_address),
    .update_type     (update_type),
    .q_count         (q_count),
    .drop_cnt        (drop_cnt),
    .mispred_cnt     (mispred_cnt)
  );

  // Reference model: a plain queue of records plus two integer counters.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ra;
    logic        rd;
    logic        ut;
    logic        mis;
  } rec_t;

  rec_t q[$];
  int   m_drop = 0;
  int   m_mis  = 0;
  bit   armed  = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] e_pc, e_ra;
    logic        e_rd, e_ut, e_flag, e_true;
    e_pc = 0; e_ra = 0; e_rd = 0; e_ut = 0; e_flag = 0; e_true = 0;
    if (q.size() != 0) begin
      e_pc = q[0].pc; e_ra = q[0].ra; e_rd = q[0].rd; e_ut = q[0].ut;
      e_flag = q[0].mis; e_true = ~q[0].mis;
    end
    check("q_count",      64'(q_count),      64'(q.size()));
    check("update_pc",    64'(update_pc),    64'(e_pc));
    check("real_address", 64'(real_address), 64'(e_ra));
    check("real_direct",  64'(real_direct),  64'(e_rd));
    check("update_type",  64'(update_type),  64'(e_ut));
    check("pred_flag",    64'(pred_flag),    64'(e_flag));
    check("pred_true",    64'(pred_true),    64'(e_true));
    check("drop_cnt",     64'(drop_cnt),     64'(m_drop));
    check("mispred_cnt",  64'(mispred_cnt),  64'(m_mis));
  endtask

  // One clock: compare the settled outputs, present new inputs, advance
  // the model by the rules for this edge, then let the edge happen.
  task automatic step(input logic rst_n, input logic v, input logic st,
                      input logic [31:0] pc, input logic pd, input logic [31:0] pa,
                      input logic rd, input logic [31:0] ra, input logic ut);
    bit   do_pop, do_push;
    rec_t r;
    @(negedge clk);
    if (armed) check_outputs();
    resetn = rst_n; ex_valid = v; stallreq = st; ex_pc = pc;
    ex_pred_direct = pd; ex_pred_address = pa; ex_real_direct = rd;
    ex_real_address = ra; ex_update_type = ut;
    if (!rst_n) begin
      q.delete(); m_drop = 0; m_mis = 0; armed = 1;
    end else begin
      do_pop  = (q.size() != 0) && !st;
      do_push = v && ((q.size() < DEPTH) || do_pop);
      if (do_pop) begin
        if (q[0].mis && m_mis < CMAX) m_mis++;
        void'(q.pop_front());
      end
      if (do_push) begin
        r.pc = pc; r.ra = ra; r.rd = rd; r.ut = ut;
        r.mis = (pd != rd) || (rd && (pa != ra));
        q.push_back(r);
      end else if (v && m_drop < CMAX) begin
        m_drop++;
      end
    end
    @(posedge clk);
  endtask

  task automatic idle(input logic st);
    step(1, 0, st, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic push_ok(input logic st, input logic [31:0] pc);
    step(1, 1, st, pc, 1, 32'h2000, 1, 32'h2000, 0);
  endtask

  initial begin
    // Reset held for two cycles with a valid record on the input.
    step(0, 1, 0, 32'h1234, 1, 32'h1, 0, 32'h2, 1);
    step(0, 1, 0, 32'h1234, 1, 32'h1, 0, 32'h2, 1);
    idle(0);

    // Correctly predicted taken branch.
    push_ok(0, 32'h1000);
    idle(0);
    idle(0);

    // Taken branch with a wrong target.
    step(1, 1, 0, 32'h1100, 1, 32'h2000, 1, 32'h2004, 1);
    idle(0);
    idle(0);

    // Stall buffering: five pushes into four slots, then drain.
    for (int i = 0; i < 5; i++) push_ok(1, 32'h10 + 32'(4 * i));
    for (int i = 0; i < 6; i++) idle(0);

    // Full queue accepting a new record while popping.
    for (int i = 0; i < 4; i++) push_ok(1, 32'h30 + 32'(i));
    push_ok(0, 32'h40);
    for (int i = 0; i < 6; i++) idle(0);

    // Drop counter saturation.
    for (int i = 0; i < 24; i++) push_ok(1, 32'h500 + 32'(i));
    for (int i = 0; i < 5; i++) idle(0);

    // Back-to-back traffic across pointer wrap, with mispredicts mixed in
    // to saturate mispred_cnt as well.
    for (int i = 0; i < 3 * DEPTH; i++)
      step(1, 1, 0, 32'h800 + 32'(i), 1'(i), 32'h2000, 1, 32'h2000, 0);
    for (int i = 0; i < 20; i++)
      step(1, 1, 0, 32'h900 + 32'(i), 0, 32'h0, 1, 32'h3000, 1);
    idle(0);

    // Reset mid-operation with a partly filled queue.
    for (int i = 0; i < 3; i++) push_ok(1, 32'hA00 + 32'(i));
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 9) < 3),
           $urandom,
           1'($urandom),
           ($urandom_range(0, 1) != 0) ? 32'h2000 : 32'h2004,
           1'($urandom),
           ($urandom_range(0, 2) != 0) ? 32'h2000 : 32'h2004,
           1'($urandom));
    end
    idle(0);
    idle(0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
